// File: rtl/pixel_adjust_if.sv
// Brightness/contrast control pulses plus the RGB pixel stream in and out of pixel_adjust.
// The master side drives the pulses and input pixels; the slave side returns adjusted pixels and the active levels.
interface pixel_adjust_if;
  logic              frame_en;
  logic              binc;
  logic              bdec;
  logic              cinc;
  logic              cdec;
  logic              in_valid;
  logic [7:0]        r_in;
  logic [7:0]        g_in;
  logic [7:0]        b_in;
  logic              out_valid;
  logic [7:0]        r_out;
  logic [7:0]        g_out;
  logic [7:0]        b_out;
  logic signed [8:0] b_level;
  logic [5:0]        c_level;

  modport master (
    output frame_en, binc, bdec, cinc, cdec, in_valid, r_in, g_in, b_in,
    input  out_valid, r_out, g_out, b_out, b_level, c_level
  );

  modport slave (
    input  frame_en, binc, bdec, cinc, cdec, in_valid, r_in, g_in, b_in,
    output out_valid, r_out, g_out, b_out, b_level, c_level
  );
endinterface

// File: rtl/pixel_adjust.sv
// Frame-synchronous brightness/contrast adjust: pending settings track the control pulses,
// active settings load on frame_en, and a 2-stage saturating pipeline applies them per channel.
module pixel_adjust #(
  parameter int B_STEP    = 8,
  parameter int B_LIMIT   = 128,
  parameter int C_STEP    = 1,
  parameter int C_MAX     = 32,
  parameter int C_DEFAULT = 16
) (
  input logic          clk,
  input logic          rst,
  pixel_adjust_if.slave bus
);

  logic signed [8:0]  r_pb;
  logic signed [8:0]  r_ab;
  logic [5:0]         r_pc;
  logic [5:0]         r_ac;
  logic signed [8:0]  w_pb_nxt;
  logic [5:0]         w_pc_nxt;
  int                 w_b_sum;
  int                 w_c_sum;

  logic               r_v1;
  logic signed [10:0] r_s1_r;
  logic signed [10:0] r_s1_g;
  logic signed [10:0] r_s1_b;
  logic               r_v2;
  logic [7:0]         r_r_out;
  logic [7:0]         r_g_out;
  logic [7:0]         r_b_out;

  // Stage 1: gain about mid-grey, result kept wide and signed so stage 2 can saturate once.
  function automatic logic signed [10:0] f_stage1(input logic [7:0] p, input logic [5:0] g);
    logic signed [15:0] w_d;
    logic signed [15:0] w_prod;
    w_d    = $signed({8'd0, p}) - 16'sd128;
    w_prod = w_d * $signed({10'd0, g});
    return 11'((w_prod >>> 4) + 16'sd128);
  endfunction

  function automatic logic [7:0] f_stage2(input logic signed [10:0] s, input logic signed [8:0] b);
    logic signed [11:0] w_y;
    w_y = $signed({s[10], s}) + $signed({{3{b[8]}}, b});
    if (w_y < 12'sd0) begin
      return 8'd0;
    end else if (w_y > 12'sd255) begin
      return 8'hff;
    end else begin
      return w_y[7:0];
    end
  endfunction

  // Pending updates are evaluated in int so the saturation test never sees a wrapped value.
  always_comb begin
    w_b_sum  = int'(r_pb);
    w_c_sum  = int'(r_pc);
    if (bus.binc && !bus.bdec) begin
      w_b_sum = int'(r_pb) + B_STEP;
      if (w_b_sum > B_LIMIT - 1) begin
        w_b_sum = B_LIMIT - 1;
      end
    end else if (bus.bdec && !bus.binc) begin
      w_b_sum = int'(r_pb) - B_STEP;
      if (w_b_sum < -B_LIMIT) begin
        w_b_sum = -B_LIMIT;
      end
    end
    if (bus.cinc && !bus.cdec) begin
      w_c_sum = int'(r_pc) + C_STEP;
      if (w_c_sum > C_MAX) begin
        w_c_sum = C_MAX;
      end
    end else if (bus.cdec && !bus.cinc) begin
      w_c_sum = int'(r_pc) - C_STEP;
      if (w_c_sum < 0) begin
        w_c_sum = 0;
      end
    end
    w_pb_nxt = 9'(w_b_sum);
    w_pc_nxt = 6'(w_c_sum);
  end

  // Active settings take the pre-update pending value, so a pulse on the frame edge waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pb <= '0;
      r_ab <= '0;
      r_pc <= 6'(C_DEFAULT);
      r_ac <= 6'(C_DEFAULT);
    end else begin
      r_pb <= w_pb_nxt;
      r_pc <= w_pc_nxt;
      if (bus.frame_en) begin
        r_ab <= r_pb;
        r_ac <= r_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_s1_r  <= '0;
      r_s1_g  <= '0;
      r_s1_b  <= '0;
      r_v2    <= 1'b0;
      r_r_out <= '0;
      r_g_out <= '0;
      r_b_out <= '0;
    end else begin
      r_v1 <= bus.in_valid;
      r_v2 <= r_v1;
      if (bus.in_valid) begin
        r_s1_r <= f_stage1(bus.r_in, r_ac);
        r_s1_g <= f_stage1(bus.g_in, r_ac);
        r_s1_b <= f_stage1(bus.b_in, r_ac);
      end
      if (r_v1) begin
        r_r_out <= f_stage2(r_s1_r, r_ab);
        r_g_out <= f_stage2(r_s1_g, r_ab);
        r_b_out <= f_stage2(r_s1_b, r_ab);
      end
    end
  end

  assign bus.out_valid = r_v2;
  assign bus.r_out     = r_r_out;
  assign bus.g_out     = r_g_out;
  assign bus.b_out     = r_b_out;
  assign bus.b_level   = r_ab;
  assign bus.c_level   = r_ac;

endmodule

// File: tb/tb_pixel_adjust.sv
// Directed bench for pixel_adjust: integer reference model checked every cycle, plus literal spot checks.
module tb_pixel_adjust;
  logic clk = 1'b0;
  logic rst;
  pixel_adjust_if bus();

  pixel_adjust dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // reference state: settings and the one pixel held between the two stages
  int m_pb, m_pc, m_ab, m_ac;
  bit m_v1;
  int m_s1 [3];
  bit e_v;
  int e_pix [3];
  int e_b, e_c;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic step(input bit rs, input bit fe, input bit bi, input bit bd,
                      input bit ci, input bit cd, input bit v,
                      input int r, input int g, input int b);
    int p [3];
    @(negedge clk);
    rst          = rs;
    bus.frame_en = fe;
    bus.binc     = bi;
    bus.bdec     = bd;
    bus.cinc     = ci;
    bus.cdec     = cd;
    bus.in_valid = v;
    bus.r_in     = 8'(r);
    bus.g_in     = 8'(g);
    bus.b_in     = 8'(b);
    p[0] = r; p[1] = g; p[2] = b;
    @(posedge clk);
    if (rs) begin
      m_pb = 0; m_ab = 0; m_pc = 16; m_ac = 16;
      m_v1 = 0; e_v = 0;
      for (int k = 0; k < 3; k++) e_pix[k] = 0;
    end else begin
      e_v = m_v1;
      if (m_v1)
        for (int k = 0; k < 3; k++) e_pix[k] = clampi(m_s1[k] + m_ab, 0, 255);
      m_v1 = v;
      if (v)
        for (int k = 0; k < 3; k++) m_s1[k] = (((p[k] - 128) * m_ac) >>> 4) + 128;
      if (fe) begin
        m_ab = m_pb;
        m_ac = m_pc;
      end
      if (bi && !bd) m_pb = clampi(m_pb + 8, -128, 127);
      if (bd && !bi) m_pb = clampi(m_pb - 8, -128, 127);
      if (ci && !cd) m_pc = clampi(m_pc + 1, 0, 32);
      if (cd && !ci) m_pc = clampi(m_pc - 1, 0, 32);
    end
    e_b = m_ab;
    e_c = m_ac;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pix(input int r, input int g, input int b);
    step(0, 0, 0, 0, 0, 0, 1, r, g, b);
  endtask

  task automatic lit_px(input string nm, input int r, input int g, input int b);
    chk({nm, ".valid"}, int'(bus.out_valid), 1);
    chk({nm, ".r"}, int'(bus.r_out), r);
    chk({nm, ".g"}, int'(bus.g_out), g);
    chk({nm, ".b"}, int'(bus.b_out), b);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.out_valid", int'(bus.out_valid), int'(e_v));
      if (e_v) begin
        chk("model.r_out", int'(bus.r_out), e_pix[0]);
        chk("model.g_out", int'(bus.g_out), e_pix[1]);
        chk("model.b_out", int'(bus.b_out), e_pix[2]);
      end
      chk("model.b_level", int'(bus.b_level), e_b);
      chk("model.c_level", int'(bus.c_level), e_c);
    end
  end

  initial begin
    rst = 1'b1;
    bus.frame_en = 0; bus.binc = 0; bus.bdec = 0; bus.cinc = 0; bus.cdec = 0;
    bus.in_valid = 0; bus.r_in = 0; bus.g_in = 0; bus.b_in = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst.out_valid", int'(bus.out_valid), 0);
    chk("rst.r_out", int'(bus.r_out), 0);
    chk("rst.b_level", int'(bus.b_level), 0);
    chk("rst.c_level", int'(bus.c_level), 16);
    chk_en = 1'b1;

    // identity
    pix(10, 128, 250);
    #1 chk("ident.early", int'(bus.out_valid), 0);
    idle(1);
    #1 lit_px("ident", 10, 128, 250);

    // brightness +24, unchanged until the frame edge
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    pix(240, 100, 0);
    idle(1);
    #1 lit_px("pre_frame", 240, 100, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("b24.level", int'(bus.b_level), 24);
    pix(240, 100, 0);
    idle(1);
    #1 lit_px("b24", 255, 124, 24);

    // brightness floor
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("bmin.level", int'(bus.b_level), -128);
    pix(100, 255, 128);
    idle(1);
    #1 lit_px("bmin", 0, 127, 0);

    // contrast ceiling from a clean reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("cmax.level", int'(bus.c_level), 32);
    pix(192, 64, 130);
    idle(1);
    #1 lit_px("cmax", 255, 0, 132);

    // sustained burst with settings changing underneath it
    step(0, 0, 1, 0, 0, 1, 1, 200, 10, 129);
    pix(0, 255, 127);
    step(0, 1, 0, 0, 0, 0, 1, 90, 160, 33);
    pix(128, 17, 240);
    pix(5, 250, 140);
    idle(2);

    // simultaneous pulses hold; pulse on the frame edge defers
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("both.level", int'(bus.b_level), 0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("coinc.level", int'(bus.b_level), 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("next.level", int'(bus.b_level), 8);

    // contrast floor
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("cmin.level", int'(bus.c_level), 0);
    pix(0, 255, 77);
    idle(1);
    #1 lit_px("cmin", 136, 136, 136);

    // reset with pixels in flight
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("b16.level", int'(bus.b_level), 16);
    pix(50, 60, 70);
    step(1, 0, 0, 0, 0, 0, 1, 80, 90, 100);
    #1;
    chk("flush.out_valid", int'(bus.out_valid), 0);
    chk("flush.b_level", int'(bus.b_level), 0);
    chk("flush.c_level", int'(bus.c_level), 16);
    idle(1);
    #1 chk("flush.out_valid2", int'(bus.out_valid), 0);
    idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
